song_writer: RTL

SONG_WRITER -- requirements
Module: song_writer

---
 rtl/song_writer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/song_writer.sv
`default_nettype none
// ============================================================================
//  Module   : song_writer
//  Captures a live note stream into one song-memory slot as {note,duration}
//  run-length entries, closed by a zero terminator word.
//  Revision : 1.0 - initial release
// ============================================================================
module song_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        record,
    input  logic [1:0]  song,
    input  logic [5:0]  note_in,
    input  logic        beat,
    output logic        wr_en,
    output logic [6:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        recording,
    output logic        record_done,
    output logic        full
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_TERM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [5:0] C_DUR_MAX    = 6'd63;
    localparam logic [4:0] C_LAST_ENTRY = 5'd30;

    logic [2:0]  state_q,       state_d;
    logic [1:0]  song_q,        song_d;
    logic [4:0]  index_q,       index_d;
    logic [5:0]  dur_q,         dur_d;
    logic [5:0]  cur_note_q,    cur_note_d;
    logic        full_q,        full_d;
    logic        wr_en_q,       wr_en_d;
    logic [6:0]  wr_addr_q,     wr_addr_d;
    logic [11:0] wr_data_q,     wr_data_d;
    logic        record_done_q, record_done_d;

    logic w_change;
    logic w_flush;
    logic w_full_hit;

    // A beat closes the running entry on a new note or a saturated duration;
    // dropping record closes it regardless of any coincident beat.
    assign w_change   = beat && ((note_in != cur_note_q) || (dur_q == C_DUR_MAX));
    assign w_flush    = (state_q == S_ACCUM) && (!record || w_change);
    assign w_full_hit = w_flush && (index_q == C_LAST_ENTRY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            song_q        <= 2'd0;
            index_q       <= 5'd0;
            dur_q         <= 6'd0;
            cur_note_q    <= 6'd0;
            full_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 7'd0;
            wr_data_q     <= 12'd0;
            record_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            song_q        <= song_d;
            index_q       <= index_d;
            dur_q         <= dur_d;
            cur_note_q    <= cur_note_d;
            full_q        <= full_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            record_done_q <= record_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (record) state_d = S_ARM;
            end
            S_ARM: begin
                if (!record)   state_d = S_TERM;
                else if (beat) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (!record || w_full_hit) state_d = S_TERM;
            end
            S_TERM: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!record) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        song_d        = song_q;
        index_d       = index_q;
        dur_d         = dur_q;
        cur_note_d    = cur_note_q;
        full_d        = full_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = 7'd0;
        wr_data_d     = 12'd0;
        record_done_d = 1'b0;
        recording     = (state_q == S_ARM) || (state_q == S_ACCUM);

        case (state_q)
            S_IDLE: begin
                if (record) begin
                    song_d  = song;
                    index_d = 5'd0;
                    dur_d   = 6'd0;
                    full_d  = 1'b0;
                end
            end
            S_ARM: begin
                if (record && beat) begin
                    cur_note_d = note_in;
                    dur_d      = 6'd1;
                end
            end
            S_ACCUM: begin
                if (w_flush) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {song_q, index_q};
                    wr_data_d = {cur_note_q, dur_q};
                    index_d   = index_q + 5'd1;
                    if (index_q == C_LAST_ENTRY) full_d = 1'b1;
                end
                if (record && beat) begin
                    if (w_change) begin
                        cur_note_d = note_in;
                        dur_d      = 6'd1;
                    end else begin
                        dur_d      = dur_q + 6'd1;
                    end
                end
            end
            S_TERM: begin
                wr_en_d       = 1'b1;
                wr_addr_d     = {song_q, index_q};
                wr_data_d     = 12'd0;
                record_done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign record_done = record_done_q;
    assign full        = full_q;

endmodule
`default_nettype wire
